// File: rtl/traffic_light_controller.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_controller
// Description : Two-road traffic light Moore FSM paced by a 1 Hz enable tick.
//               Fixed six-phase cycle with main/side greens, shared yellow
//               and all-red clearance durations. Lamps decode from the state
//               register only. Optional pedestrian walk lamp during side
//               green is built only when TRAFFIC_PED_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_controller #(
    parameter int unsigned GREEN_MAIN_S = 10,
    parameter int unsigned GREEN_SIDE_S = 6,
    parameter int unsigned YELLOW_S     = 3,
    parameter int unsigned ALL_RED_S    = 1
) (
    input  logic       clk,
    input  logic       light_reset_n,
    input  logic       Hz1_enable,
    input  logic       ped_request,
    output logic       main_red,
    output logic       main_yellow,
    output logic       main_green,
    output logic       side_red,
    output logic       side_yellow,
    output logic       side_green,
    output logic       walk,
    output logic [2:0] state_out
);

    localparam logic [2:0] c_MAIN_GREEN  = 3'd0;
    localparam logic [2:0] c_MAIN_YELLOW = 3'd1;
    localparam logic [2:0] c_ALL_RED1    = 3'd2;
    localparam logic [2:0] c_SIDE_GREEN  = 3'd3;
    localparam logic [2:0] c_SIDE_YELLOW = 3'd4;
    localparam logic [2:0] c_ALL_RED2    = 3'd5;

    // A zero duration is promoted to one pulse so every phase is visible.
    localparam logic [7:0] c_DUR_MAIN   = (GREEN_MAIN_S == 0) ? 8'd1 : 8'(GREEN_MAIN_S);
    localparam logic [7:0] c_DUR_SIDE   = (GREEN_SIDE_S == 0) ? 8'd1 : 8'(GREEN_SIDE_S);
    localparam logic [7:0] c_DUR_YELLOW = (YELLOW_S     == 0) ? 8'd1 : 8'(YELLOW_S);
    localparam logic [7:0] c_DUR_ALLRED = (ALL_RED_S    == 0) ? 8'd1 : 8'(ALL_RED_S);

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic [7:0] sec_cnt_q;
    logic [7:0] sec_cnt_d;
    logic [7:0] w_dur;
    logic [2:0] w_next;
    logic       w_legal;

    // State and phase counter; reset parks the controller in the final all-red.
    always_ff @(posedge clk or negedge light_reset_n) begin
        if (!light_reset_n) begin
            state_q   <= c_ALL_RED2;
            sec_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            sec_cnt_q <= sec_cnt_d;
        end
    end

    // Next-state: advance the phase counter on each tick, move on at end of phase.
    always_comb begin
        w_dur     = c_DUR_ALLRED;
        w_next    = c_ALL_RED2;
        w_legal   = 1'b1;
        state_d   = state_q;
        sec_cnt_d = sec_cnt_q;
        case (state_q)
            c_MAIN_GREEN:  begin w_dur = c_DUR_MAIN;   w_next = c_MAIN_YELLOW; end
            c_MAIN_YELLOW: begin w_dur = c_DUR_YELLOW; w_next = c_ALL_RED1;    end
            c_ALL_RED1:    begin w_dur = c_DUR_ALLRED; w_next = c_SIDE_GREEN;  end
            c_SIDE_GREEN:  begin w_dur = c_DUR_SIDE;   w_next = c_SIDE_YELLOW; end
            c_SIDE_YELLOW: begin w_dur = c_DUR_YELLOW; w_next = c_ALL_RED2;    end
            c_ALL_RED2:    begin w_dur = c_DUR_ALLRED; w_next = c_MAIN_GREEN;  end
            default:       w_legal = 1'b0;
        endcase
        if (!w_legal) begin
            // Corrupted state recovers through a safe all-red phase.
            state_d   = c_ALL_RED2;
            sec_cnt_d = 8'd0;
        end else if (Hz1_enable) begin
            if (sec_cnt_q == (w_dur - 8'd1)) begin
                state_d   = w_next;
                sec_cnt_d = 8'd0;
            end else begin
                sec_cnt_d = sec_cnt_q + 8'd1;
            end
        end
    end

`ifdef TRAFFIC_PED_EN
    logic ped_pending_q;
    logic walk_active_q;
    logic w_enter_side;
    logic w_exit_side;

    assign w_enter_side = (state_q != c_SIDE_GREEN) && (state_d == c_SIDE_GREEN);
    assign w_exit_side  = (state_q == c_SIDE_GREEN) && (state_d != c_SIDE_GREEN);

    // Pedestrian request latch; consumed when side green begins.
    always_ff @(posedge clk or negedge light_reset_n) begin
        if (!light_reset_n) begin
            ped_pending_q <= 1'b0;
            walk_active_q <= 1'b0;
        end else begin
            if (w_enter_side) begin
                walk_active_q <= ped_pending_q | ped_request;
                ped_pending_q <= 1'b0;
            end else begin
                if (ped_request) begin
                    ped_pending_q <= 1'b1;
                end
                if (w_exit_side) begin
                    walk_active_q <= 1'b0;
                end
            end
        end
    end
`else
    logic w_unused_ped;
    assign w_unused_ped = ped_request;
`endif

    // Lamp decode from registered state: exactly one lamp per road.
    always_comb begin
        main_red    = 1'b1;
        main_yellow = 1'b0;
        main_green  = 1'b0;
        side_red    = 1'b1;
        side_yellow = 1'b0;
        side_green  = 1'b0;
        state_out   = state_q;
        case (state_q)
            c_MAIN_GREEN:  begin main_red = 1'b0; main_green  = 1'b1; end
            c_MAIN_YELLOW: begin main_red = 1'b0; main_yellow = 1'b1; end
            c_SIDE_GREEN:  begin side_red = 1'b0; side_green  = 1'b1; end
            c_SIDE_YELLOW: begin side_red = 1'b0; side_yellow = 1'b1; end
            default:       ;
        endcase
`ifdef TRAFFIC_PED_EN
        walk = walk_active_q & (state_q == c_SIDE_GREEN);
`else
        walk = 1'b0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_light_controller
// Description : Directed, table-driven bench for traffic_light_controller,
//               with hand-written sequences for reset, zero duration and
//               pedestrian walk behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hz;
    logic       ped;
    logic       mr, my, mg, sr, sy, sg, wk;
    logic [2:0] st;
    logic       mr0, my0, mg0, sr0, sy0, sg0, wk0;
    logic [2:0] st0;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    traffic_light_controller dut (
        .clk(clk), .light_reset_n(rst_n), .Hz1_enable(hz), .ped_request(ped),
        .main_red(mr), .main_yellow(my), .main_green(mg),
        .side_red(sr), .side_yellow(sy), .side_green(sg),
        .walk(wk), .state_out(st)
    );

    traffic_light_controller #(.GREEN_MAIN_S(0)) dut0 (
        .clk(clk), .light_reset_n(rst_n), .Hz1_enable(hz), .ped_request(ped),
        .main_red(mr0), .main_yellow(my0), .main_green(mg0),
        .side_red(sr0), .side_yellow(sy0), .side_green(sg0),
        .walk(wk0), .state_out(st0)
    );

`ifdef TRAFFIC_PED_EN
    localparam logic c_WALK_EXP = 1'b1;
`else
    localparam logic c_WALK_EXP = 1'b0;
`endif

    typedef struct {
        int         n;      // number of Hz1 pulses (or held-high cycles)
        bit         hold;   // 1: Hz1 held high for n consecutive cycles
        int         idle;   // extra cycles with Hz1 low before checking
        logic [2:0] exp;    // expected state_out
        string      name;
    } vec_t;

    vec_t vecs [0:17];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Expected lamps {mr,my,mg,sr,sy,sg} for a given state.
    function automatic logic [5:0] lamps_for(input logic [2:0] s);
        case (s)
            3'd0:    return 6'b001_100;
            3'd1:    return 6'b010_100;
            3'd3:    return 6'b100_001;
            3'd4:    return 6'b100_010;
            default: return 6'b100_100;
        endcase
    endfunction

    task automatic check_main(input string name, input logic [2:0] exp);
        check({name, "_state"}, {5'd0, st}, {5'd0, exp});
        check({name, "_lamps"}, {2'd0, mr, my, mg, sr, sy, sg}, {2'd0, lamps_for(exp)});
    endtask

    task automatic pulse();
        @(negedge clk) hz = 1'b1;
        @(negedge clk) hz = 1'b0;
    endtask

    task automatic advance_until(input logic [2:0] target, input string name);
        int k;
        for (k = 0; k < 40 && st !== target; k++) pulse();
        check({name, "_reached"}, {7'd0, (st === target)}, 8'd1);
    endtask

    // Every cycle: one lamp per road on both instances; walk only in side green.
    always @(negedge clk) begin
        n_checks++;
        if (!($onehot({mr, my, mg}) && $onehot({sr, sy, sg}) &&
              $onehot({mr0, my0, mg0}) && $onehot({sr0, sy0, sg0}))) begin
            n_fails++;
            $display("FAIL onehot: main=%b side=%b main0=%b side0=%b expected one-hot",
                     {mr, my, mg}, {sr, sy, sg}, {mr0, my0, mg0}, {sr0, sy0, sg0});
        end
        if (wk && !sg) begin
            n_fails++;
            $display("FAIL walk_outside_side_green: walk=%b side_green=%b", wk, sg);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1, 0, 0,    3'd0, "first_pulse_mg"};
        vecs[1]  = '{9, 0, 0,    3'd0, "mg_hold9"};
        vecs[2]  = '{1, 0, 0,    3'd1, "mg_to_my"};
        vecs[3]  = '{2, 0, 0,    3'd1, "my_hold2"};
        vecs[4]  = '{1, 0, 0,    3'd2, "my_to_ar1"};
        vecs[5]  = '{1, 0, 0,    3'd3, "ar1_to_sg"};
        vecs[6]  = '{5, 0, 0,    3'd3, "sg_hold5"};
        vecs[7]  = '{1, 0, 0,    3'd4, "sg_to_sy"};
        vecs[8]  = '{2, 0, 0,    3'd4, "sy_hold2"};
        vecs[9]  = '{1, 0, 0,    3'd5, "sy_to_ar2"};
        vecs[10] = '{1, 0, 0,    3'd0, "ar2_to_mg"};
        vecs[11] = '{4, 1, 0,    3'd0, "level4_mg"};
        vecs[12] = '{5, 0, 0,    3'd0, "mg_cnt9"};
        vecs[13] = '{1, 0, 0,    3'd1, "level_counted_my"};
        vecs[14] = '{0, 0, 1000, 3'd1, "idle1000"};
        vecs[15] = '{3, 0, 0,    3'd2, "my_to_ar1_b"};
        vecs[16] = '{1, 0, 0,    3'd3, "ar1_to_sg_b"};
        vecs[17] = '{5, 0, 0,    3'd3, "sg_pulse5"};

        rst_n = 1'b0;
        hz    = 1'b0;
        ped   = 1'b0;

        // Reset held while the tick toggles.
        repeat (10) @(negedge clk) hz = ~hz;
        @(negedge clk) hz = 1'b0;
        check_main("reset", 3'd5);
        check("reset_walk", {7'd0, wk}, 8'd0);

        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].hold) begin
                @(negedge clk) hz = 1'b1;
                repeat (vecs[i].n) @(negedge clk);
                hz = 1'b0;
            end else begin
                repeat (vecs[i].n) pulse();
            end
            repeat (vecs[i].idle) @(negedge clk);
            check_main(vecs[i].name, vecs[i].exp);
        end

        // Asynchronous reset in the middle of side green.
        #2 rst_n = 1'b0;
        #1 check_main("midphase_reset", 3'd5);
        @(negedge clk) rst_n = 1'b1;
        pulse();
        check_main("post_reset_mg", 3'd0);
        check("dur0_mg_entry", {5'd0, st0}, 8'd0);
        pulse();
        check("dur0_mg_one_pulse", {5'd0, st0}, 8'd1);
        check_main("default_still_mg", 3'd0);

        // Pedestrian request during main green serves the next side green.
        @(negedge clk) ped = 1'b1;
        @(negedge clk) ped = 1'b0;
        advance_until(3'd3, "to_sg_ped");
        for (int k = 0; k < 6; k++) begin
            check("walk_in_sg", {7'd0, wk}, {7'd0, c_WALK_EXP});
            check("sg_during_walk", {5'd0, st}, 8'd3);
            pulse();
        end
        check_main("after_walk_sy", 3'd4);
        check("walk_off_after_sg", {7'd0, wk}, 8'd0);
        advance_until(3'd3, "to_sg_noped");
        check("walk_no_request", {7'd0, wk}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
